// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- byte FIFO feeding an 8N1 UART transmitter.
//
// Bytes written with data_valid while ready is high are queued in a circular
// buffer. The transmitter pops the head byte and sends it as a start bit
// (low), eight data bits LSB first, and a stop bit (high). Each bit lasts
// divisor = (sysclk_frequency*1000)/baud_rate clock cycles, so a frame is
// always 10*divisor cycles. When bytes are still queued at the end of a stop
// bit, the next frame starts immediately, with no idle gap.
//
// Parameters
//   sysclk_frequency : system clock in 100 kHz units (1250 = 125.0 MHz)
//   baud_rate        : line rate in 100-baud units (1152 = 115200 baud)
//   fifo_depth_log2  : FIFO holds 2**fifo_depth_log2 bytes
//
// Ports
//   clk        : sole clock, rising edge
//   reset_in   : synchronous active-high reset
//   data_in    : byte to enqueue
//   data_valid : write request qualifying data_in
//   ready      : FIFO can accept a byte this cycle
//   fifo_count : bytes queued, excluding the byte being shifted out
//   busy       : a frame is on the line or the FIFO is non-empty
//   txd        : registered serial output, idle high
module uart_tx_fifo #(
  parameter int sysclk_frequency = 1250,
  parameter int baud_rate        = 1152,
  parameter int fifo_depth_log2  = 4
) (
  input  logic                     clk,
  input  logic                     reset_in,
  input  logic [7:0]               data_in,
  input  logic                     data_valid,
  output logic                     ready,
  output logic [fifo_depth_log2:0] fifo_count,
  output logic                     busy,
  output logic                     txd
);

  localparam int DEPTH   = 1 << fifo_depth_log2;
  localparam int CNT_W   = fifo_depth_log2 + 1;
  localparam int DIVISOR = (sysclk_frequency * 1000) / baud_rate;
  localparam int TIMER_W = $clog2(DIVISOR);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(DIVISOR - 1);
  localparam logic [CNT_W-1:0]   DEPTH_CNT  = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                     state;
  state_t                     state_nxt;
  logic [TIMER_W-1:0]         timer;
  logic [TIMER_W-1:0]         timer_nxt;
  logic [2:0]                 bit_cnt;
  logic [2:0]                 bit_cnt_nxt;
  logic [7:0]                 shreg;
  logic [7:0]                 shreg_nxt;
  logic                       txd_nxt;

  logic [7:0]                 mem [DEPTH];
  logic [fifo_depth_log2-1:0] wr_ptr;
  logic [fifo_depth_log2-1:0] rd_ptr;
  logic                       push;
  logic                       pop;
  logic                       fifo_nonempty;

  assign ready         = (fifo_count < DEPTH_CNT);
  assign push          = data_valid & ready;
  assign fifo_nonempty = (fifo_count != '0);
  assign busy          = (state != IDLE) | fifo_nonempty;

  // Next-state logic: bit timing, frame sequencing and FIFO pop decision.
  // Pops look only at the registered count, so a byte written into an empty
  // FIFO is popped on the following cycle, not the one that writes it.
  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    pop         = 1'b0;
    txd_nxt     = 1'b1;

    case (state)
      IDLE: begin
        if (fifo_nonempty) begin
          pop       = 1'b1;
          shreg_nxt = mem[rd_ptr];
          timer_nxt = TIMER_LOAD;
          state_nxt = START;
        end
      end

      START: begin
        txd_nxt = 1'b0;
        if (timer == '0) begin
          timer_nxt   = TIMER_LOAD;
          bit_cnt_nxt = 3'd0;
          state_nxt   = DATA;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end

      DATA: begin
        txd_nxt = shreg[0];
        if (timer == '0) begin
          timer_nxt = TIMER_LOAD;
          if (bit_cnt == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            shreg_nxt   = shreg >> 1;
          end
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end

      STOP: begin
        if (timer == '0) begin
          // Chain straight into the next frame when bytes are waiting.
          if (fifo_nonempty) begin
            pop       = 1'b1;
            shreg_nxt = mem[rd_ptr];
            timer_nxt = TIMER_LOAD;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // State, timer, shifter, line register and FIFO bookkeeping.
  // txd is registered from the current state, so the line lags the state by
  // one cycle; every bit still lasts exactly divisor cycles.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      state      <= IDLE;
      timer      <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      txd        <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      txd     <= txd_nxt;

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage array: data only, never reset; writes are blocked during reset.
  always_ff @(posedge clk) begin
    if (push && !reset_in) begin
      mem[wr_ptr] <= data_in;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int SYSCLK = 4;
  localparam int BAUD   = 1000;
  localparam int DLOG2  = 4;
  localparam int DEPTH  = 16;
  localparam int FRAME  = 40;

  logic             clk = 1'b0;
  logic             reset_in;
  logic [7:0]       data_in;
  logic             data_valid;
  logic             ready;
  logic [DLOG2:0]   fifo_count;
  logic             busy;
  logic             txd;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .sysclk_frequency(SYSCLK),
    .baud_rate(BAUD),
    .fifo_depth_log2(DLOG2)
  ) dut (
    .clk(clk),
    .reset_in(reset_in),
    .data_in(data_in),
    .data_valid(data_valid),
    .ready(ready),
    .fifo_count(fifo_count),
    .busy(busy),
    .txd(txd)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Frame-level reference: FIFO occupancy, line activity and the expected
  // byte stream. A frame occupies the line for FRAME cycles after its pop.
  logic [7:0] exp_q[$];
  int  m_cnt  = 0;
  bit  m_line = 1'b0;
  int  m_left = 0;
  bit  m_acc;
  bit  m_pop;
  bit  mon_en = 1'b0;

  always @(posedge clk) begin
    if (reset_in) begin
      m_cnt  <= 0;
      m_line <= 1'b0;
      m_left <= 0;
      exp_q.delete();
    end else begin
      m_acc = data_valid && (m_cnt < DEPTH);
      m_pop = (m_cnt > 0) && (!m_line || m_left == 1);
      if (m_acc) exp_q.push_back(data_in);
      m_cnt <= m_cnt + int'(m_acc) - int'(m_pop);
      if (m_pop) begin
        m_line <= 1'b1;
        m_left <= FRAME;
      end else if (m_line) begin
        if (m_left == 1) m_line <= 1'b0;
        m_left <= m_left - 1;
      end
    end
  end

  // Status comparison every cycle plus an independent serial receiver that
  // decodes txd and pops the scoreboard on each completed frame.
  int   cyc = 0;
  int   last_start = 0;
  int   prev_start = 0;
  int   n_starts = 0;
  int   n_frames = 0;
  bit   rx_active = 1'b0;
  int   rx_t = 0;
  logic [7:0] rx_byte = 8'h00;

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      check("fifo_count", fifo_count, m_cnt);
      check("ready", ready, m_cnt < DEPTH);
      check("busy", busy, m_line || (m_cnt != 0));
      if (reset_in) begin
        rx_active = 1'b0;
      end else if (!rx_active) begin
        if (txd == 1'b0) begin
          rx_active  = 1'b1;
          rx_t       = 0;
          prev_start = last_start;
          last_start = cyc;
          n_starts++;
        end
      end else begin
        rx_t++;
        if (rx_t == 2) check("start_bit", txd, 1'b0);
        if (rx_t >= 6 && rx_t <= 34 && ((rx_t - 6) % 4) == 0)
          rx_byte[(rx_t - 6) / 4] = txd;
        if (rx_t == 38) begin
          check("stop_bit", txd, 1'b1);
          check("rx_pending", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) check("rx_byte", rx_byte, exp_q.pop_front());
          n_frames++;
          rx_active = 1'b0;
        end
      end
    end
  end

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_line || m_cnt != 0 || rx_active) && n < max_cyc) begin
      step();
      n++;
    end
    // Extra time so any unexpected trailing frame is fully decoded.
    repeat (50) step();
    check("drain_empty", exp_q.size(), 0);
    check("drain_idle", busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] wave;
    logic [39:0] wave_exp;
    logic [7:0]  b;
    int          peak;
    int          s0;
    int          f0;
    int          lo;
    int          hi;
    int          n_rdy;
    bit          low_seen;

    reset_in   = 1'b1;
    data_valid = 1'b0;
    data_in    = 8'h00;
    repeat (3) step();
    check("reset_txd", txd, 1'b1);
    check("reset_count", fifo_count, 0);
    check("reset_ready", ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    // Writes during reset are ignored.
    data_valid = 1'b1;
    data_in    = 8'hEE;
    step();
    check("reset_write_ignored", fifo_count, 0);
    data_valid = 1'b0;
    reset_in   = 1'b0;
    mon_en     = 1'b1;
    step();
    check("post_reset_ready", ready, 1'b1);
    check("post_reset_busy", busy, 1'b0);

    // Single 0x55 frame: latency and exact waveform.
    b = 8'h55;
    for (int i = 0; i < 40; i++) begin
      if (i < 4)       wave_exp[i] = 1'b0;
      else if (i < 36) wave_exp[i] = b[(i - 4) / 4];
      else             wave_exp[i] = 1'b1;
    end
    data_in    = 8'h55;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    check("lat_edge_n", txd, 1'b1);
    step();
    check("lat_edge_n1", txd, 1'b1);
    for (int i = 0; i < 40; i++) begin
      step();
      wave[i] = txd;
      if (i == 20) check("busy_mid_frame", busy, 1'b1);
    end
    check("wave_0x55", wave, wave_exp);
    check("busy_after_frame", busy, 1'b0);
    step();
    check("idle_txd", txd, 1'b1);
    drain(200);

    // Back-to-back 0x00, 0xFF.
    s0         = n_starts;
    data_valid = 1'b1;
    data_in    = 8'h00;
    step();
    data_in    = 8'hFF;
    step();
    data_valid = 1'b0;
    check("b2b_count", fifo_count, 1);
    peak = int'(fifo_count);
    repeat (90) begin
      step();
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    check("b2b_peak", peak, 1);
    check("b2b_starts", n_starts - s0, 2);
    check("b2b_gap", last_start - prev_start, FRAME);
    drain(200);

    // Overfill: one byte goes straight to the shifter, so 17 writes fit and
    // the 18th (0x11) is rejected at count 16.
    f0         = n_frames;
    data_valid = 1'b1;
    for (int i = 0; i < 18; i++) begin
      data_in = 8'(i);
      step();
      if (i == 16) begin
        check("full_count", fifo_count, 16);
        check("full_ready", ready, 1'b0);
      end
    end
    data_valid = 1'b0;
    check("reject_count", fifo_count, 16);
    drain(18 * FRAME + 100);
    check("overfill_frames", n_frames - f0, 17);

    // Full FIFO with data_valid held high: each pop frees one slot that the
    // next write refills; pointers wrap repeatedly.
    data_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      data_in = 8'(8'h80 + i);
      step();
    end
    check("hold_full", fifo_count, 16);
    lo    = 99;
    hi    = 0;
    n_rdy = 0;
    for (int i = 0; i < 130; i++) begin
      data_in = 8'(8'hA0 + i);
      step();
      if (int'(fifo_count) < lo) lo = int'(fifo_count);
      if (int'(fifo_count) > hi) hi = int'(fifo_count);
      if (ready) n_rdy++;
    end
    data_valid = 1'b0;
    check("hold_min", lo, 15);
    check("hold_max", hi, 16);
    check("hold_refills", n_rdy, 3);
    drain(22 * FRAME + 100);

    // Reset in the middle of 0xA5 with three bytes queued.
    data_valid = 1'b1;
    data_in    = 8'hA5;
    step();
    data_in    = 8'h11;
    step();
    data_in    = 8'h22;
    step();
    data_in    = 8'h33;
    step();
    data_valid = 1'b0;
    check("pre_reset_count", fifo_count, 3);
    repeat (16) step();
    check("pre_reset_txd_low", txd, 1'b0);
    s0       = n_starts;
    reset_in = 1'b1;
    step();
    reset_in = 1'b0;
    check("rst_txd", txd, 1'b1);
    check("rst_count", fifo_count, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", ready, 1'b1);
    low_seen = 1'b0;
    repeat (100) begin
      step();
      if (txd == 1'b0) low_seen = 1'b1;
    end
    check("rst_no_start", low_seen, 1'b0);
    check("rst_starts", n_starts - s0, 0);

    // Simultaneous write and pop at count 5.
    data_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_in = 8'(8'h60 + i);
      step();
    end
    data_valid = 1'b0;
    check("six_count", fifo_count, 5);
    repeat (35) step();
    check("pre_sim_count", fifo_count, 5);
    data_valid = 1'b1;
    data_in    = 8'h77;
    step();
    data_valid = 1'b0;
    check("sim_count", fifo_count, 5);
    step();
    check("sim_next_start", txd, 1'b0);
    drain(8 * FRAME + 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
